// File: rtl/engine_param_rx_if.sv
// rtl/engine_param_rx_if.sv - broadcast-link byte handshake and parameter packet handshake
interface engine_param_rx_if #(
    parameter int NUM_BYTES = 9
);
    logic                   in_rts;
    logic                   out_rtr;
    logic [7:0]             in_data;
    logic                   param_valid;
    logic                   param_ready;
    logic [8*NUM_BYTES-1:0] param_data;
    logic                   busy;
    logic                   timeout_err;

    modport master (
        output in_rts, in_data, param_ready,
        input  out_rtr, param_valid, param_data, busy, timeout_err
    );

    modport slave (
        input  in_rts, in_data, param_ready,
        output out_rtr, param_valid, param_data, busy, timeout_err
    );
endinterface

// File: rtl/engine_param_rx.sv
// rtl/engine_param_rx.sv - assembles fixed-length parameter packets from the broadcast byte link
module engine_param_rx #(
    parameter int NUM_BYTES   = 9,
    parameter int TIMEOUT_CYC = 1024
) (
    input logic             clk,
    input logic             rst_,
    engine_param_rx_if.slave lk
);
    localparam int W  = 8 * NUM_BYTES;
    localparam int SW = (NUM_BYTES > 1) ? 8 * (NUM_BYTES - 1) : 8;
    localparam int CW = $clog2(NUM_BYTES + 1);
    localparam int IW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(NUM_BYTES - 1);
    localparam logic [IW-1:0] IDLE_LAST = IW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

    typedef enum logic [1:0] {S_INIT, S_COLLECT, S_PRESENT} state_t;

    state_t         state;
    logic           rtr_q;
    logic           valid_q;
    logic           terr_q;
    logic [W-1:0]   param_q;
    logic [SW-1:0]  shift_q;
    logic [CW-1:0]  cnt;
    logic [IW-1:0]  idle;
    logic [W-1:0]   shifted;
    logic           accept;

    // Only the bytes still to be shifted out are stored; the newest byte comes straight off the bus.
    if (NUM_BYTES == 1) begin : g_one
        assign shifted = lk.in_data;
    end else begin : g_many
        assign shifted = {shift_q, lk.in_data};
    end

    assign accept = lk.in_rts && rtr_q;

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state   <= S_INIT;
            rtr_q   <= 1'b0;
            valid_q <= 1'b0;
            terr_q  <= 1'b0;
            param_q <= '0;
            shift_q <= '0;
            cnt     <= '0;
            idle    <= '0;
        end else begin
            terr_q <= 1'b0;
            case (state)
                S_INIT: begin
                    state <= S_COLLECT;
                    rtr_q <= 1'b1;
                end
                S_COLLECT: begin
                    if (accept) begin
                        shift_q <= shifted[SW-1:0];
                        idle    <= '0;
                        if (cnt == CNT_LAST) begin
                            param_q <= shifted;
                            valid_q <= 1'b1;
                            rtr_q   <= 1'b0;
                            cnt     <= '0;
                            state   <= S_PRESENT;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end else if (TIMEOUT_CYC > 0 && cnt != '0) begin
                        // Expiry happens on the edge that closes the TIMEOUT_CYC-th idle cycle.
                        if (idle == IDLE_LAST) begin
                            cnt     <= '0;
                            shift_q <= '0;
                            idle    <= '0;
                            terr_q  <= 1'b1;
                        end else begin
                            idle <= idle + IW'(1);
                        end
                    end
                end
                S_PRESENT: begin
                    if (lk.param_ready) begin
                        valid_q <= 1'b0;
                        rtr_q   <= 1'b1;
                        state   <= S_COLLECT;
                    end
                end
                default: begin
                    state <= S_INIT;
                    rtr_q <= 1'b0;
                end
            endcase
        end
    end

    assign lk.out_rtr     = rtr_q;
    assign lk.param_valid = valid_q;
    assign lk.param_data  = param_q;
    assign lk.timeout_err = terr_q;
    assign lk.busy        = (state != S_COLLECT) || (cnt != '0);
endmodule

// File: tb/tb_engine_param_rx.sv
// tb/tb_engine_param_rx.sv - directed self-checking bench for engine_param_rx
module tb_engine_param_rx;
    logic clk;
    logic rst_;
    int   total;
    int   bad;

    engine_param_rx_if #(.NUM_BYTES(9)) lk ();

    engine_param_rx #(.NUM_BYTES(9), .TIMEOUT_CYC(16)) dut (
        .clk  (clk),
        .rst_ (rst_),
        .lk   (lk)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [71:0] PKT_A = 72'h00_10_00_20_00_30_00_40_AA;
    localparam logic [71:0] PKT_B = 72'h01_02_03_04_05_06_07_08_09;
    localparam logic [71:0] PKT_C = 72'hDE_AD_BE_EF_12_34_56_78_9A;
    localparam logic [71:0] PKT_D = 72'h11_22_33_44_55_66_77_88_99;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        lk.in_rts  = 1'b1;
        lk.in_data = b;
        tick();
        lk.in_rts  = 1'b0;
        lk.in_data = 8'h5A;
    endtask

    task automatic send_pkt(input logic [71:0] p, input int maxgap);
        logic [71:0] v;
        v = p;
        for (int i = 0; i < 9; i++) begin
            if (i > 0 && maxgap > 0) repeat ($urandom_range(0, maxgap)) tick();
            send_byte(v[71-8*i -: 8]);
        end
    endtask

    task automatic release_pkt();
        lk.param_ready = 1'b1;
        tick();
        lk.param_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_ = 1'b0;
        lk.in_rts = 1'b0;
        lk.in_data = 8'h00;
        lk.param_ready = 1'b0;
        repeat (3) tick();
        total++;
        if (lk.out_rtr !== 1'b0 || lk.param_valid !== 1'b0 || lk.timeout_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_ctrl rtr=%b valid=%b terr=%b want 0 0 0", lk.out_rtr, lk.param_valid, lk.timeout_err);
        end
        total++;
        if (lk.param_data !== 72'h0 || lk.busy !== 1'b1) begin
            bad++;
            $display("FAIL reset_data data=%h busy=%b want 0 1", lk.param_data, lk.busy);
        end
        rst_ = 1'b1;
        #1;
        total++;
        if (lk.out_rtr !== 1'b0) begin
            bad++;
            $display("FAIL init_rtr got=%b want 0", lk.out_rtr);
        end
        tick();
        total++;
        if (lk.out_rtr !== 1'b1 || lk.busy !== 1'b0) begin
            bad++;
            $display("FAIL collect_entry rtr=%b busy=%b want 1 0", lk.out_rtr, lk.busy);
        end
    endtask

    task automatic test_hold();
        send_pkt(PKT_A, 0);
        total++;
        if (lk.param_valid !== 1'b1 || lk.out_rtr !== 1'b0 || lk.busy !== 1'b1) begin
            bad++;
            $display("FAIL hold_rise valid=%b rtr=%b busy=%b want 1 0 1", lk.param_valid, lk.out_rtr, lk.busy);
        end
        total++;
        if (lk.param_data !== PKT_A) begin
            bad++;
            $display("FAIL hold_data got=%h want %h", lk.param_data, PKT_A);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if (lk.param_valid !== 1'b1 || lk.out_rtr !== 1'b0 || lk.param_data !== PKT_A) begin
                bad++;
                $display("FAIL hold_stable cyc=%0d valid=%b rtr=%b data=%h want 1 0 %h", i, lk.param_valid, lk.out_rtr, lk.param_data, PKT_A);
            end
        end
        release_pkt();
        total++;
        if (lk.param_valid !== 1'b0 || lk.out_rtr !== 1'b1 || lk.busy !== 1'b0) begin
            bad++;
            $display("FAIL hold_release valid=%b rtr=%b busy=%b want 0 1 0", lk.param_valid, lk.out_rtr, lk.busy);
        end
        total++;
        if (lk.param_data !== PKT_A) begin
            bad++;
            $display("FAIL hold_keep got=%h want %h", lk.param_data, PKT_A);
        end
    endtask

    task automatic test_back_to_back();
        lk.param_ready = 1'b1;
        send_pkt(PKT_A, 0);
        total++;
        if (lk.param_valid !== 1'b1 || lk.param_data !== PKT_A) begin
            bad++;
            $display("FAIL b2b_first valid=%b data=%h want 1 %h", lk.param_valid, lk.param_data, PKT_A);
        end
        tick();
        total++;
        if (lk.param_valid !== 1'b0 || lk.out_rtr !== 1'b1) begin
            bad++;
            $display("FAIL b2b_pulse valid=%b rtr=%b want 0 1", lk.param_valid, lk.out_rtr);
        end
        send_pkt(PKT_B, 0);
        total++;
        if (lk.param_valid !== 1'b1 || lk.param_data !== PKT_B) begin
            bad++;
            $display("FAIL b2b_second valid=%b data=%h want 1 %h", lk.param_valid, lk.param_data, PKT_B);
        end
        tick();
        total++;
        if (lk.param_valid !== 1'b0) begin
            bad++;
            $display("FAIL b2b_second_pulse valid=%b want 0", lk.param_valid);
        end
        lk.param_ready = 1'b0;
    endtask

    task automatic test_present_ignore();
        send_pkt(PKT_B, 0);
        lk.in_rts  = 1'b1;
        lk.in_data = 8'hFF;
        repeat (4) tick();
        lk.in_rts  = 1'b0;
        total++;
        if (lk.param_valid !== 1'b1 || lk.param_data !== PKT_B) begin
            bad++;
            $display("FAIL present_ignore valid=%b data=%h want 1 %h", lk.param_valid, lk.param_data, PKT_B);
        end
        release_pkt();
        total++;
        if (lk.busy !== 1'b0) begin
            bad++;
            $display("FAIL present_nocount busy=%b want 0", lk.busy);
        end
        send_pkt(PKT_C, 3);
        total++;
        if (lk.param_valid !== 1'b1 || lk.param_data !== PKT_C) begin
            bad++;
            $display("FAIL gapped_pkt valid=%b data=%h want 1 %h", lk.param_valid, lk.param_data, PKT_C);
        end
        release_pkt();
    endtask

    task automatic test_timeout();
        send_byte(8'h77);
        send_byte(8'h66);
        send_byte(8'h55);
        for (int i = 1; i <= 15; i++) begin
            tick();
            total++;
            if (lk.timeout_err !== 1'b0 || lk.busy !== 1'b1) begin
                bad++;
                $display("FAIL timeout_early idle=%0d terr=%b busy=%b want 0 1", i, lk.timeout_err, lk.busy);
            end
        end
        tick();
        total++;
        if (lk.timeout_err !== 1'b1 || lk.busy !== 1'b0 || lk.out_rtr !== 1'b1) begin
            bad++;
            $display("FAIL timeout_fire terr=%b busy=%b rtr=%b want 1 0 1", lk.timeout_err, lk.busy, lk.out_rtr);
        end
        tick();
        total++;
        if (lk.timeout_err !== 1'b0) begin
            bad++;
            $display("FAIL timeout_pulse terr=%b want 0", lk.timeout_err);
        end
        send_pkt(PKT_D, 0);
        total++;
        if (lk.param_valid !== 1'b1 || lk.param_data !== PKT_D) begin
            bad++;
            $display("FAIL timeout_clean valid=%b data=%h want 1 %h", lk.param_valid, lk.param_data, PKT_D);
        end
        release_pkt();
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        repeat (15) tick();
        send_byte(8'h04);
        total++;
        if (lk.timeout_err !== 1'b0 || lk.busy !== 1'b1) begin
            bad++;
            $display("FAIL timeout_accept_wins terr=%b busy=%b want 0 1", lk.timeout_err, lk.busy);
        end
        repeat (16) tick();
        total++;
        if (lk.timeout_err !== 1'b1) begin
            bad++;
            $display("FAIL timeout_restart terr=%b want 1", lk.timeout_err);
        end
        tick();
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 5; i++) send_byte(8'hC0 + 8'(i));
        #3;
        rst_ = 1'b0;
        #1;
        total++;
        if (lk.out_rtr !== 1'b0 || lk.param_valid !== 1'b0 || lk.param_data !== 72'h0 || lk.busy !== 1'b1) begin
            bad++;
            $display("FAIL async_reset rtr=%b valid=%b data=%h busy=%b want 0 0 0 1", lk.out_rtr, lk.param_valid, lk.param_data, lk.busy);
        end
        tick();
        rst_ = 1'b1;
        tick();
        send_pkt(PKT_A, 1);
        total++;
        if (lk.param_valid !== 1'b1 || lk.param_data !== PKT_A) begin
            bad++;
            $display("FAIL post_reset_pkt valid=%b data=%h want 1 %h", lk.param_valid, lk.param_data, PKT_A);
        end
        release_pkt();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_hold();
        test_back_to_back();
        test_present_ignore();
        test_timeout();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
